// File: rtl/sram_bist_pkg.sv
// Shared definitions for the SRAM March C- BIST mux.
//   state_t    : top-level FSM states (IDLE / ACC / ADV / DONE)
//   elem_t     : one March element: direction, op count, per-op write flag and data polarity
//   elem_info  : the March C- element table, E0..E5
//   BUSY_RESP  : read data returned to the mgmt port while the test owns the SRAM
package sram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_ADV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // pol = 0 selects the background pattern, pol = 1 its complement.
    typedef struct packed {
        logic down;
        logic two_op;
        logic we0;
        logic pol0;
        logic we1;
        logic pol1;
    } elem_t;

    localparam logic [2:0]  LAST_ELEM = 3'd5;
    localparam logic [31:0] BUSY_RESP = 32'hDEAD_B157;

    // E0 up w0 | E1 up r0,w1 | E2 up r1,w0 | E3 down r0,w1 | E4 down r1,w0 | E5 up r0
    function automatic elem_t elem_info(input logic [2:0] elem);
        elem_t info;
        info = '0;
        case (elem)
            3'd0: info = '{down: 1'b0, two_op: 1'b0, we0: 1'b1, pol0: 1'b0, we1: 1'b0, pol1: 1'b0};
            3'd1: info = '{down: 1'b0, two_op: 1'b1, we0: 1'b0, pol0: 1'b0, we1: 1'b1, pol1: 1'b1};
            3'd2: info = '{down: 1'b0, two_op: 1'b1, we0: 1'b0, pol0: 1'b1, we1: 1'b1, pol1: 1'b0};
            3'd3: info = '{down: 1'b1, two_op: 1'b1, we0: 1'b0, pol0: 1'b0, we1: 1'b1, pol1: 1'b1};
            3'd4: info = '{down: 1'b1, two_op: 1'b1, we0: 1'b0, pol0: 1'b1, we1: 1'b1, pol1: 1'b0};
            3'd5: info = '{down: 1'b0, two_op: 1'b0, we0: 1'b0, pol0: 1'b0, we1: 1'b0, pol1: 1'b0};
            default: info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/sram_bist_march_seq.sv
// March C- sequencer: walks element / op / word index.
//   clk, srst   : clock, synchronous active-high reset
//   step        : advance to the next access
//   clear       : restart at E0, op 0, index 0
//   idx         : word index of the current access
//   we          : current access is a write
//   exp_pol     : data polarity (write data or expected read data)
//   last        : current access is the final one of the test
module sram_bist_march_seq
    import sram_bist_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              step,
    input  logic              clear,
    output logic [ADDR_W-1:0] idx,
    output logic              we,
    output logic              exp_pol,
    output logic              last
);

    localparam logic [ADDR_W-1:0] IDX_MAX = ADDR_W'(DEPTH - 1);

    logic [2:0]        elem_reg;
    logic              op_reg;
    logic [ADDR_W-1:0] idx_reg;

    elem_t cur;
    elem_t nxt;
    logic  op_last;
    logic  idx_end;

    assign cur     = elem_info(elem_reg);
    assign nxt     = elem_info(elem_reg + 3'd1);
    assign op_last = !cur.two_op || op_reg;
    assign idx_end = cur.down ? (idx_reg == '0) : (idx_reg == IDX_MAX);

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            elem_reg <= 3'd0;
            op_reg   <= 1'b0;
            idx_reg  <= '0;
        end else if (step) begin
            if (!op_last) begin
                op_reg <= 1'b1;
            end else begin
                op_reg <= 1'b0;
                if (!idx_end) begin
                    idx_reg <= cur.down ? idx_reg - 1'b1 : idx_reg + 1'b1;
                end else if (elem_reg != LAST_ELEM) begin
                    // Each element starts from its own end of the array; no wrap across elements.
                    elem_reg <= elem_reg + 3'd1;
                    idx_reg  <= nxt.down ? IDX_MAX : '0;
                end
            end
        end
    end

    assign idx     = idx_reg;
    assign we      = op_reg ? cur.we1 : cur.we0;
    assign exp_pol = op_reg ? cur.pol1 : cur.pol0;
    assign last    = (elem_reg == LAST_ELEM) && op_last && idx_end;

endmodule

// File: rtl/sram_wb_bist_mux.sv
// Wishbone mux in front of the SRAM slave with a built-in March C- tester.
//   wb_clk_i, wb_rst_i      : clock, synchronous active-high reset
//   wbs_*                   : mgmt Wishbone slave port (passed through while idle)
//   m_*                     : Wishbone master port to the SRAM slave
//   bist_start_i            : rising edge requests a test run
//   bist_busy/done/fail/tmo : run status (done/fail/tmo sticky until next run)
//   fail_adr_o, fail_dat_o  : word index and read data of the first failure
module sram_wb_bist_mux
    import sram_bist_pkg::*;
#(
    parameter int          DEPTH        = 4096,
    parameter int          ADDR_W       = 12,
    parameter logic [31:0] BASE_ADR     = 32'h3000_0000,
    parameter logic [31:0] DATA_BG      = 32'h0000_0000,
    parameter int          TIMEOUT      = 255,
    parameter bit          STOP_ON_FAIL = 1'b1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              m_cyc_o,
    output logic              m_stb_o,
    output logic              m_we_o,
    output logic [3:0]        m_sel_o,
    output logic [31:0]       m_adr_o,
    output logic [31:0]       m_dat_o,
    input  logic              m_ack_i,
    input  logic [31:0]       m_dat_i,
    input  logic              bist_start_i,
    output logic              bist_busy_o,
    output logic              bist_done_o,
    output logic              bist_fail_o,
    output logic              bist_tmo_o,
    output logic [ADDR_W-1:0] fail_adr_o,
    output logic [31:0]       fail_dat_o
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            state_reg, state_next;
    logic              start_d_reg, pending_reg, busy_ack_reg;
    logic              done_reg, fail_reg, tmo_reg;
    logic [ADDR_W-1:0] fail_adr_reg;
    logic [31:0]       fail_dat_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;

    logic [ADDR_W-1:0] seq_idx;
    logic              seq_we, seq_pol, seq_last;
    logic              take, step, in_test;
    logic              rd_mismatch, tmo_hit;
    logic [31:0]       exp_word;

    assign in_test     = (state_reg == ST_ACC) || (state_reg == ST_ADV);
    // A pending start waits for any open mgmt cycle to close.
    assign take        = (state_reg == ST_IDLE) && pending_reg && !wbs_cyc_i;
    assign step        = (state_reg == ST_ADV);
    assign exp_word    = seq_pol ? ~DATA_BG : DATA_BG;
    assign rd_mismatch = (state_reg == ST_ACC) && m_ack_i && !seq_we && (m_dat_i != exp_word);
    assign tmo_hit     = (state_reg == ST_ACC) && !m_ack_i && (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));

    sram_bist_march_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk     (wb_clk_i),
        .srst    (wb_rst_i),
        .step    (step),
        .clear   (take),
        .idx     (seq_idx),
        .we      (seq_we),
        .exp_pol (seq_pol),
        .last    (seq_last)
    );

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (take) state_next = ST_ACC;
            ST_ACC: begin
                if (m_ack_i) begin
                    if ((rd_mismatch && STOP_ON_FAIL) || seq_last) state_next = ST_DONE;
                    else                                           state_next = ST_ADV;
                end else if (tmo_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_ADV:  state_next = ST_ACC;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus outputs
    always_comb begin
        m_cyc_o     = 1'b0;
        m_stb_o     = 1'b0;
        m_we_o      = 1'b0;
        m_sel_o     = 4'h0;
        m_adr_o     = 32'h0;
        m_dat_o     = 32'h0;
        wbs_ack_o   = busy_ack_reg;
        wbs_dat_o   = BUSY_RESP;
        bist_busy_o = in_test;
        case (state_reg)
            ST_IDLE: begin
                // A busy-mode ack can still be in flight on the first idle cycle;
                // hold the strobe back so the SRAM does not answer the same request twice.
                m_cyc_o   = wbs_cyc_i;
                m_stb_o   = wbs_stb_i && !busy_ack_reg;
                m_we_o    = wbs_we_i;
                m_sel_o   = wbs_sel_i;
                m_adr_o   = wbs_adr_i;
                m_dat_o   = wbs_dat_i;
                wbs_ack_o = m_ack_i || busy_ack_reg;
                if (!busy_ack_reg) wbs_dat_o = m_dat_i;
            end
            ST_ACC: begin
                m_cyc_o = 1'b1;
                m_stb_o = 1'b1;
                m_we_o  = seq_we;
                m_sel_o = 4'hF;
                m_adr_o = BASE_ADR + (32'(seq_idx) << 2);
                m_dat_o = exp_word;
            end
            default: ;
        endcase
    end

    // Start detection, busy-mode mgmt ack, timeout counter and status
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            start_d_reg  <= 1'b0;
            pending_reg  <= 1'b0;
            busy_ack_reg <= 1'b0;
            done_reg     <= 1'b0;
            fail_reg     <= 1'b0;
            tmo_reg      <= 1'b0;
            fail_adr_reg <= '0;
            fail_dat_reg <= 32'h0;
            tmo_cnt_reg  <= '0;
        end else begin
            start_d_reg  <= bist_start_i;
            busy_ack_reg <= (state_reg != ST_IDLE) && wbs_cyc_i && wbs_stb_i && !busy_ack_reg;

            if (take)                                      pending_reg <= 1'b0;
            else if (bist_start_i && !start_d_reg && !in_test) pending_reg <= 1'b1;

            // Restarts on every new strobe because ACC is always entered from a non-ACC state.
            if (state_reg != ST_ACC) tmo_cnt_reg <= '0;
            else if (!m_ack_i)       tmo_cnt_reg <= tmo_cnt_reg + 1'b1;

            if (take) begin
                done_reg     <= 1'b0;
                fail_reg     <= 1'b0;
                tmo_reg      <= 1'b0;
                fail_adr_reg <= '0;
                fail_dat_reg <= 32'h0;
            end else begin
                if (rd_mismatch && !fail_reg) begin
                    fail_reg     <= 1'b1;
                    fail_adr_reg <= seq_idx;
                    fail_dat_reg <= m_dat_i;
                end
                if (tmo_hit) begin
                    fail_reg <= 1'b1;
                    tmo_reg  <= 1'b1;
                    if (!fail_reg) begin
                        fail_adr_reg <= seq_idx;
                        fail_dat_reg <= 32'h0;
                    end
                end
                if (state_reg == ST_ACC && state_next == ST_DONE) done_reg <= 1'b1;
            end
        end
    end

    assign bist_done_o = done_reg;
    assign bist_fail_o = fail_reg;
    assign bist_tmo_o  = tmo_reg;
    assign fail_adr_o  = fail_adr_reg;
    assign fail_dat_o  = fail_dat_reg;

endmodule
